// File: rtl/alu_operand_sequencer.sv
// Multi-cycle operand front end for an external combinational 16-bit ALU.
// Sequences register-file reads into A/B, captures the ALU result and optionally writes it back.
module alu_operand_sequencer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREG   = 8,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_reg,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [REG_AW-1:0] req_rn,
  input  logic [REG_AW-1:0] req_rm,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [1:0]        req_shift,
  input  logic              req_wb,
  output logic [DATA_W-1:0] alu_ain,
  output logic [DATA_W-1:0] alu_bin,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_z,
  output logic [DATA_W-1:0] result,
  output logic              status_z,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ_A = 3'd1,
    READ_B = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic              z_q, done_q, wb_q;
  logic [1:0]        op_q, shift_q;
  logic [REG_AW-1:0] rn_q, rm_q, rd_q;

  logic              accept, ld_en, a_en, b_en, c_en, wr_en;
  logic [REG_AW-1:0] rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] b_shifted;

  // Next-state and per-state enables
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ld_en      = 1'b0;
    a_en       = 1'b0;
    b_en       = 1'b0;
    c_en       = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        if (ld_valid) begin
          ld_en = 1'b1;
        end else if (req_valid) begin
          accept     = 1'b1;
          state_next = READ_A;
        end
      end
      READ_A: begin
        a_en       = 1'b1;
        state_next = READ_B;
      end
      READ_B: begin
        b_en       = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        c_en       = 1'b1;
        state_next = WRITE;
      end
      WRITE: begin
        wr_en      = wb_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = (state == IDLE) && !ld_valid;

  // Single read port, shared between the A and B fetch cycles
  assign rd_idx  = (state == READ_A) ? rn_q : rm_q;
  assign rd_data = rf[rd_idx];

  always_comb begin
    b_shifted = b_q;
    case (shift_q)
      2'b01:   b_shifted = {b_q[DATA_W-2:0], 1'b0};
      2'b10:   b_shifted = {1'b0, b_q[DATA_W-1:1]};
      2'b11:   b_shifted = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
      default: b_shifted = b_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      done_q  <= 1'b0;
      wb_q    <= 1'b0;
      op_q    <= '0;
      shift_q <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
    end else begin
      state  <= state_next;
      done_q <= (state == WRITE);
      if (accept) begin
        op_q    <= req_op;
        rn_q    <= req_rn;
        rm_q    <= req_rm;
        rd_q    <= req_rd;
        shift_q <= req_shift;
        wb_q    <= req_wb;
      end
      if (a_en) a_q <= rd_data;
      if (b_en) b_q <= rd_data;
      if (c_en) begin
        c_q <= alu_out;
        z_q <= alu_z;
      end
      // ld only happens in IDLE and write-back only in WRITE, so they never collide
      if (ld_en)      rf[ld_reg] <= ld_data;
      else if (wr_en) rf[rd_q]   <= c_q;
    end
  end

  assign alu_ain  = a_q;
  assign alu_bin  = b_shifted;
  assign alu_op   = op_q;
  assign result   = c_q;
  assign status_z = z_q;
  assign done     = done_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a behavioural ALU attached to its ALU ports.
module tb_alu_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_valid;
  logic [2:0]  ld_reg;
  logic [15:0] ld_data;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_rn, req_rm, req_rd;
  logic [1:0]  req_shift;
  logic        req_wb;
  logic [15:0] alu_ain, alu_bin, alu_out, result;
  logic [1:0]  alu_op;
  logic        alu_z, status_z, done;

  typedef struct packed {
    logic [15:0] res;
    logic        z;
    logic [15:0] bin;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model[8];
  logic [15:0] obs_bin;
  int          checks = 0;
  int          errors = 0;

  alu_operand_sequencer dut (
    .clk(clk), .reset_n(reset_n),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rn(req_rn), .req_rm(req_rm), .req_rd(req_rd),
    .req_shift(req_shift), .req_wb(req_wb),
    .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z),
    .result(result), .status_z(status_z), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    case (op)
      2'b00:   return a + b;
      2'b01:   return a - b;
      2'b10:   return a & b;
      default: return ~b;
    endcase
  endfunction

  function automatic logic [15:0] shift_f(input logic [15:0] b, input logic [1:0] sh);
    case (sh)
      2'b01:   return b << 1;
      2'b10:   return b >> 1;
      2'b11:   return 16'($signed(b) >>> 1);
      default: return b;
    endcase
  endfunction

  assign alu_out = alu_f(alu_ain, alu_bin, alu_op);
  assign alu_z   = (alu_out == 16'h0000);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_r%0d", tag, i), 32'(dut.rf[i]), 32'(model[i]));
  endtask

  task automatic do_ld(input logic [2:0] r, input logic [15:0] d);
    @(negedge clk);
    ld_valid = 1'b1; ld_reg = r; ld_data = d;
    model[r] = d;
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  // Drive a request at a falling edge and return just after the accepting rising edge
  task automatic send_req(input logic [1:0] op, input logic [2:0] rn, input logic [2:0] rm,
                          input logic [2:0] rd, input logic [1:0] sh, input logic wb,
                          input bit expect_done);
    exp_t e;
    bit   acc = 0;
    e.bin = shift_f(model[rm], sh);
    e.res = alu_f(model[rn], e.bin, op);
    e.z   = (e.res == 16'h0000);
    if (expect_done) begin
      sb.push_back(e);
      if (wb) model[rd] = e.res;
    end
    req_op = op; req_rn = rn; req_rm = rm; req_rd = rd; req_shift = sh; req_wb = wb;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      if (req_ready) begin
        @(posedge clk);
        acc = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input bit poke);
    exp_t e;
    bit   seen = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (k == 0) req_valid = 1'b0;
      if (poke && k == 1) begin
        ld_valid = 1'b1; ld_reg = 3'd5; ld_data = 16'hDEAD; req_valid = 1'b1;
        #1 chk("busy_ready", 32'(req_ready), 32'd0);
      end
      if (poke && k == 2) begin
        ld_valid = 1'b0; req_valid = 1'b0;
      end
      if (k == 2) obs_bin = alu_bin;
      if (done) begin
        seen = 1;
        chk("latency", 32'(k), 32'd4);
        chk("ready_at_done", 32'(req_ready), 32'd1);
        if (sb.size() == 0) begin
          chk("sb_empty", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("alu_bin", 32'(obs_bin), 32'(e.bin));
          chk("result", 32'(result), 32'(e.res));
          chk("status_z", 32'(status_z), 32'(e.z));
        end
      end
    end
    if (!seen) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_done;
    reset_n = 1'b0; ld_valid = 1'b0; ld_reg = '0; ld_data = '0;
    req_valid = 1'b0; req_op = '0; req_rn = '0; req_rm = '0; req_rd = '0;
    req_shift = '0; req_wb = 1'b0; obs_bin = '0;
    for (int i = 0; i < 8; i++) model[i] = '0;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk_regs("rst");
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_status_z", 32'(status_z), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_ain", 32'(alu_ain), 32'd0);

    // Add with write-back
    do_ld(3'd1, 16'd5);
    do_ld(3'd2, 16'd3);
    send_req(2'b00, 3'd1, 3'd2, 3'd3, 2'b00, 1'b1, 1);
    wait_done(0);
    chk("add_r3", 32'(dut.rf[3]), 32'd8);

    // LSR1 then compare without write-back
    do_ld(3'd1, 16'd7);
    do_ld(3'd2, 16'h000E);
    send_req(2'b01, 3'd1, 3'd2, 3'd3, 2'b10, 1'b0, 1);
    wait_done(0);
    chk("cmp_r3_kept", 32'(dut.rf[3]), 32'd8);

    // ASR keeps MSB; not-B
    do_ld(3'd2, 16'h8000);
    send_req(2'b11, 3'd0, 3'd2, 3'd4, 2'b11, 1'b1, 1);
    wait_done(0);

    // Add wrap to zero
    do_ld(3'd1, 16'hFFFF);
    do_ld(3'd2, 16'h0001);
    send_req(2'b00, 3'd1, 3'd2, 3'd5, 2'b00, 1'b1, 1);
    wait_done(0);

    // LSL and register aliasing, then back-to-back dependency
    send_req(2'b10, 3'd3, 3'd3, 3'd3, 2'b01, 1'b1, 1);
    wait_done(0);
    do_ld(3'd6, 16'h00F3);
    send_req(2'b00, 3'd6, 3'd6, 3'd6, 2'b01, 1'b1, 1);
    wait_done(0);
    send_req(2'b01, 3'd6, 3'd6, 3'd7, 2'b11, 1'b1, 1);
    wait_done(0);
    chk_regs("alias");

    // ld and req together: ld wins, request accepted once ld drops
    @(negedge clk);
    ld_valid = 1'b1; ld_reg = 3'd4; ld_data = 16'h1234;
    req_op = 2'b00; req_rn = 3'd4; req_rm = 3'd4; req_rd = 3'd7; req_shift = 2'b00; req_wb = 1'b1;
    req_valid = 1'b1;
    #1 chk("cont_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    ld_valid = 1'b0;
    model[4] = 16'h1234;
    chk("cont_ld_r4", 32'(dut.rf[4]), 32'h1234);
    send_req(2'b00, 3'd4, 3'd4, 3'd7, 2'b00, 1'b1, 1);
    wait_done(1);
    chk_regs("busy");

    // Random operations
    for (int n = 0; n < 10; n++) begin
      if ($urandom_range(0, 1) == 1) do_ld(3'($urandom_range(0, 7)), 16'($urandom));
      send_req(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1);
      wait_done(0);
    end
    chk_regs("rand");

    // Reset during EXEC abandons the write-back
    do_ld(3'd1, 16'd9);
    send_req(2'b00, 3'd1, 3'd1, 3'd6, 2'b00, 1'b1, 0);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_in_exec", 32'(dut.state), 32'd3);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    chk("mid_no_done", 32'(saw_done), 32'd0);
    chk("mid_idle", 32'(dut.state), 32'd0);
    chk("mid_ready", 32'(req_ready), 32'd1);
    chk("mid_result", 32'(result), 32'd0);
    chk_regs("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
